// File: rtl/rv32i_pkg.sv
// Shared constants and types for the RV32I memory stage: opcodes, func3 codes,
// the stage FSM states and the writeback / bus bundles.
package rv32i_pkg;

  localparam logic [6:0]  OP_LOAD    = 7'b0000011;
  localparam logic [6:0]  OP_STORE   = 7'b0100011;
  localparam logic [31:0] NOP_IW_DEF = 32'h0000_0013;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] iw;
    logic [31:0] pc;
    logic        wb_en;
    logic [4:0]  wb_reg;
  } wb_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational byte-lane steering for stores and lane extraction/extension for loads.
// RV32I_MISALIGN_TRAP_EN: when defined, flags misaligned halfword/word accesses.
module rv32i_lsu_align
  import rv32i_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  func3,
  input  logic [1:0]  addr,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        f3_ok,
  output logic        misalign
);

  logic [31:0] rsh;
  logic [15:0] half;
  logic        mis_raw;

  assign rsh  = rdata >> {addr, 3'b000};
  assign half = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = '0;
    wdata     = '0;
    load_data = '0;
    f3_ok     = 1'b0;
    mis_raw   = 1'b0;
    if (is_store) begin
      case (func3)
        F3_SB: begin be = 4'b0001 << addr; wdata = {4{rs2[7:0]}}; f3_ok = 1'b1; end
        F3_SH: begin
          be = 4'b0011 << {addr[1], 1'b0}; wdata = {2{rs2[15:0]}}; f3_ok = 1'b1; mis_raw = addr[0];
        end
        F3_SW: begin be = 4'hF; wdata = rs2; f3_ok = 1'b1; mis_raw = |addr; end
        default: ;
      endcase
    end else begin
      case (func3)
        F3_LB, F3_LBU: begin
          be = 4'b0001 << addr; f3_ok = 1'b1;
          load_data = (func3 == F3_LB) ? {{24{rsh[7]}}, rsh[7:0]} : {24'h0, rsh[7:0]};
        end
        F3_LH, F3_LHU: begin
          be = 4'b0011 << {addr[1], 1'b0}; f3_ok = 1'b1; mis_raw = addr[0];
          load_data = (func3 == F3_LH) ? {{16{half[15]}}, half} : {16'h0, half};
        end
        F3_LW: begin be = 4'hF; load_data = rdata; f3_ok = 1'b1; mis_raw = |addr; end
        default: ;
      endcase
    end
  end

`ifdef RV32I_MISALIGN_TRAP_EN
  assign misalign = mis_raw;
`else
  // Without the trap, low address bits are dropped and the access is aligned down.
  logic unused_mis;
  assign unused_mis = mis_raw;
  assign misalign   = 1'b0;
`endif

endmodule

// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: req/ack data bus FSM with timeout, WB register bundle and
// forwarding to decode. RV32I_MISALIGN_TRAP_EN enables the misaligned-access trap.
module rv32i_mem_stage
  import rv32i_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_IW         = NOP_IW_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_in,
  input  logic [31:0] iw_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] rs2_data_in,
  input  logic        wb_en_in,
  input  logic [4:0]  wb_reg_in,
  input  logic        w_en_in,
  output logic        stall_out,
  output logic        d_req,
  output logic        d_we,
  output logic [31:0] d_addr,
  output logic [3:0]  d_be,
  output logic [31:0] d_wdata,
  input  logic        d_ack,
  input  logic [31:0] d_rdata,
  output logic [31:0] alu_out,
  output logic [31:0] iw_out,
  output logic [31:0] pc_out,
  output logic        wb_en_out,
  output logic [4:0]  wb_reg_out,
  output logic        err_out,
  output logic        misalign_out,
  output logic        df_mem_enable,
  output logic [4:0]  df_mem_reg,
  output logic [31:0] df_mem_data
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  bus_t          bus_q, bus_n;
  wb_t           wb_q, wb_n, wb_pass, wb_bubble;
  logic          err_q, err_n, mis_q, mis_n;

  logic        is_load, is_store, is_mem, go_bus, misal, ack_hit, timeout;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, load_data;
  logic        al_f3_ok, al_mis;

  assign is_load  = iw_in[6:0] == OP_LOAD;
  assign is_store = (iw_in[6:0] == OP_STORE) && w_en_in;
  assign is_mem   = is_load | is_store;

  rv32i_lsu_align u_align (
    .is_store (is_store),
    .func3    (iw_in[14:12]),
    .addr     (alu_in[1:0]),
    .rs2      (rs2_data_in),
    .rdata    (d_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .load_data(load_data),
    .f3_ok    (al_f3_ok),
    .misalign (al_mis)
  );

  assign misal   = is_mem & al_mis;
  // Unsupported func3 and trapped accesses complete in one cycle without the bus.
  assign go_bus  = is_mem & al_f3_ok & ~misal;
  assign ack_hit = (state == BUSY) & d_ack;
  assign timeout = (state == BUSY) & ~d_ack & (cnt == CNT_LAST);

  assign stall_out = ((state == IDLE) & go_bus) | ((state == BUSY) & ~d_ack & ~timeout);

  assign df_mem_reg    = wb_reg_in;
  assign df_mem_enable = wb_en_in & (~is_load | ack_hit);
  assign df_mem_data   = (ack_hit & is_load) ? load_data : alu_in;

  assign wb_pass   = '{alu: alu_in, iw: iw_in, pc: pc_in, wb_en: wb_en_in, wb_reg: wb_reg_in};
  assign wb_bubble = '{alu: 32'h0, iw: NOP_IW, pc: 32'h0, wb_en: 1'b0, wb_reg: 5'h0};

  always_comb begin
    state_n = state;
    cnt_n   = '0;
    bus_n   = bus_q;
    wb_n    = wb_bubble;
    err_n   = 1'b0;
    mis_n   = 1'b0;
    case (state)
      IDLE: begin
        if (go_bus) begin
          state_n     = BUSY;
          bus_n.req   = 1'b1;
          bus_n.we    = is_store;
          bus_n.addr  = {alu_in[31:2], 2'b00};
          bus_n.be    = al_be;
          bus_n.wdata = al_wdata;
        end else begin
          wb_n = wb_pass;
          if (is_mem) begin
            wb_n.alu   = '0;
            wb_n.wb_en = is_load & wb_en_in & ~misal;
            mis_n      = misal;
          end
        end
      end
      BUSY: begin
        if (d_ack || timeout) begin
          state_n    = IDLE;
          bus_n.req  = 1'b0;
          bus_n.we   = 1'b0;
          bus_n.be   = '0;
          wb_n       = wb_pass;
          wb_n.wb_en = is_load & wb_en_in;
          // On timeout a load returns 0 and a store is simply dropped.
          wb_n.alu   = is_store ? alu_in : (d_ack ? load_data : 32'h0);
          err_n      = ~d_ack;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      bus_q <= '0;
      wb_q  <= wb_bubble;
      err_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      bus_q <= bus_n;
      wb_q  <= wb_n;
      err_q <= err_n;
      mis_q <= mis_n;
    end
  end

  assign d_req        = bus_q.req;
  assign d_we         = bus_q.we;
  assign d_addr       = bus_q.addr;
  assign d_be         = bus_q.be;
  assign d_wdata      = bus_q.wdata;
  assign alu_out      = wb_q.alu;
  assign iw_out       = wb_q.iw;
  assign pc_out       = wb_q.pc;
  assign wb_en_out    = wb_q.wb_en;
  assign wb_reg_out   = wb_q.wb_reg;
  assign err_out      = err_q;
  assign misalign_out = mis_q;

endmodule
